// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - 4-entry writeback FIFO merging ALU and memory/FPU results
// into one register-file write port, with a combinational hazard query.
module regfile_writeback (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [5:0]  a_reg,
   input  logic        a_float,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [5:0]  b_reg,
   input  logic        b_float,
   input  logic [31:0] b_data,
   output logic [5:0]  writeReg,
   output logic [31:0] writeData,
   output logic        regWrite,
   output logic        float,
   input  logic [5:0]  q_reg,
   input  logic        q_float,
   output logic        q_pending,
   output logic [31:0] q_data,
   output logic [2:0]  count
);

   typedef struct packed {
      logic [5:0]  rg;
      logic        fl;
      logic [31:0] data;
   } entry_t;

   entry_t      mem_q [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic        regwrite_q;
   logic [5:0]  wreg_q;
   logic [31:0] wdata_q;
   logic        wfloat_q;
   logic        a_push, b_push, pop;
   logic [1:0]  idx;

   assign a_ready = (count_q <= 3'd2);
   assign b_ready = (count_q <= 3'd3);

   // Integer register 0 is hardwired: results aimed at it are accepted and dropped.
   assign a_push = a_valid && a_ready && (a_float || (a_reg != 6'd0));
   assign b_push = b_valid && b_ready && (b_float || (b_reg != 6'd0));
   assign pop    = (count_q != 3'd0);

   always_comb begin
      wr_ptr_d = wr_ptr_q + 2'(a_push) + 2'(b_push);
      rd_ptr_d = rd_ptr_q + 2'(pop);
      count_d  = count_q + 3'(a_push) + 3'(b_push) - 3'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         count_q    <= 3'd0;
         regwrite_q <= 1'b0;
         wreg_q     <= 6'd0;
         wdata_q    <= 32'd0;
         wfloat_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (pop) begin
            regwrite_q <= 1'b1;
            wreg_q     <= mem_q[rd_ptr_q].rg;
            wdata_q    <= mem_q[rd_ptr_q].data;
            wfloat_q   <= mem_q[rd_ptr_q].fl;
         end else begin
            regwrite_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (a_push) mem_q[wr_ptr_q] <= '{rg: a_reg, fl: a_float, data: a_data};
         if (b_push) mem_q[wr_ptr_q + 2'(a_push)] <= '{rg: b_reg, fl: b_float, data: b_data};
      end
   end

   always_comb begin
      q_pending = 1'b0;
      q_data    = 32'd0;
      idx       = rd_ptr_q;
      if (regwrite_q && (wreg_q == q_reg) && (wfloat_q == q_float)) begin
         q_pending = 1'b1;
         q_data    = wdata_q;
      end
      // Walk oldest to youngest so the latest matching entry wins.
      for (int i = 0; i < 4; i++) begin
         idx = rd_ptr_q + 2'(i);
         if ((3'(i) < count_q) && (mem_q[idx].rg == q_reg) && (mem_q[idx].fl == q_float)) begin
            q_pending = 1'b1;
            q_data    = mem_q[idx].data;
         end
      end
      if (!q_float && (q_reg == 6'd0)) begin
         q_pending = 1'b0;
         q_data    = 32'd0;
      end
   end

   assign writeReg  = wreg_q;
   assign writeData = wdata_q;
   assign regWrite  = regwrite_q;
   assign float     = wfloat_q;
   assign count     = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed and random checks of regfile_writeback
// against a queue-based reference model.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, b_ready;
   logic [5:0]  a_reg = '0, b_reg = '0, q_reg = '0;
   logic        a_float = 1'b0, b_float = 1'b0, q_float = 1'b0;
   logic [31:0] a_data = '0, b_data = '0;
   logic [5:0]  writeReg;
   logic [31:0] writeData;
   logic        regWrite, wfloat;
   logic        q_pending;
   logic [31:0] q_data;
   logic [2:0]  count;

   regfile_writeback dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_float(a_float), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_float(b_float), .b_data(b_data),
      .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite), .float(wfloat),
      .q_reg(q_reg), .q_float(q_float), .q_pending(q_pending), .q_data(q_data),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  r;
      logic        f;
      logic [31:0] d;
   } ent_t;

   ent_t        fifo[$];
   logic        m_rw = 1'b0, m_fl = 1'b0, m_known = 1'b0;
   logic [5:0]  m_reg = '0;
   logic [31:0] m_data = '0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_query(input logic [5:0] qr, input logic qf,
                              output logic qp, output logic [31:0] qd);
      qp = 1'b0;
      qd = 32'd0;
      if (!(qr == 6'd0 && !qf)) begin
         if (m_rw && m_reg == qr && m_fl == qf) begin
            qp = 1'b1;
            qd = m_data;
         end
         foreach (fifo[i]) begin
            if (fifo[i].r == qr && fifo[i].f == qf) begin
               qp = 1'b1;
               qd = fifo[i].d;
            end
         end
      end
   endtask

   // One clock: drive at negedge, check before the edge, advance the model at the edge.
   task automatic step(input logic rst,
                       input logic av, input logic [5:0] ar, input logic af, input logic [31:0] ad,
                       input logic bv, input logic [5:0] br, input logic bf, input logic [31:0] bd,
                       input logic [5:0] qr, input logic qf,
                       output logic acc_a, output logic acc_b);
      int          n;
      logic        ar_m, br_m, qp_m;
      logic [31:0] qd_m;
      ent_t        e;
      rst_n = !rst;
      a_valid = av; a_reg = ar; a_float = af; a_data = ad;
      b_valid = bv; b_reg = br; b_float = bf; b_data = bd;
      q_reg = qr; q_float = qf;
      #1;
      n = fifo.size();
      ar_m = (n <= 2);
      br_m = (n <= 3);
      model_query(qr, qf, qp_m, qd_m);
      if (m_known) begin
         chk("a_ready", 32'(a_ready), 32'(ar_m));
         chk("b_ready", 32'(b_ready), 32'(br_m));
         chk("count", 32'(count), 32'(n));
         chk("regWrite", 32'(regWrite), 32'(m_rw));
         chk("writeReg", 32'(writeReg), 32'(m_reg));
         chk("writeData", writeData, m_data);
         chk("float", 32'(wfloat), 32'(m_fl));
         chk("q_pending", 32'(q_pending), 32'(qp_m));
         chk("q_data", q_data, qd_m);
      end
      acc_a = !rst && av && ar_m;
      acc_b = !rst && bv && br_m;
      @(posedge clk);
      if (rst) begin
         fifo.delete();
         m_rw = 1'b0; m_reg = '0; m_data = '0; m_fl = 1'b0;
         m_known = 1'b1;
      end else begin
         if (n > 0) begin
            e = fifo.pop_front();
            m_rw = 1'b1; m_reg = e.r; m_fl = e.f; m_data = e.d;
         end else begin
            m_rw = 1'b0;
         end
         if (acc_a && !(ar == 6'd0 && !af)) fifo.push_back('{r: ar, f: af, d: ad});
         if (acc_b && !(br == 6'd0 && !bf)) fifo.push_back('{r: br, f: bf, d: bd});
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [5:0] qr, input logic qf);
      logic xa, xb;
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, qr, qf, xa, xb);
   endtask

   initial begin
      logic        ka, kb;
      logic [31:0] adat, bdat;
      @(negedge clk);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, ka, kb);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, ka, kb);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_regWrite", 32'(regWrite), 32'd0);

      // Single write
      step(1'b0, 1'b1, 6'd1, 1'b0, 32'd44, 1'b0, '0, 1'b0, '0, '0, 1'b0, ka, kb);
      chk("single_count", 32'(count), 32'd1);
      chk("single_rw_k", 32'(regWrite), 32'd0);
      idle('0, 1'b0);
      chk("single_rw", 32'(regWrite), 32'd1);
      chk("single_reg", 32'(writeReg), 32'd1);
      chk("single_data", writeData, 32'd44);
      chk("single_float", 32'(wfloat), 32'd0);
      idle('0, 1'b0);
      chk("single_rw_off", 32'(regWrite), 32'd0);

      // Dual accept: A ahead of B
      step(1'b0, 1'b1, 6'd3, 1'b0, 32'd7, 1'b1, 6'd3, 1'b1, 32'd9, '0, 1'b0, ka, kb);
      chk("dual_count2", 32'(count), 32'd2);
      idle('0, 1'b0);
      chk("dual_count1", 32'(count), 32'd1);
      chk("dual_first", writeData, 32'd7);
      chk("dual_first_fl", 32'(wfloat), 32'd0);
      idle('0, 1'b0);
      chk("dual_count0", 32'(count), 32'd0);
      chk("dual_second", writeData, 32'd9);
      chk("dual_second_fl", 32'(wfloat), 32'd1);
      idle('0, 1'b0);

      // Backpressure: both sources held valid, data advances only when accepted
      adat = 32'h100; bdat = 32'h200;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 6'd10, 1'b0, adat, 1'b1, 6'd11, 1'b1, bdat, '0, 1'b0, ka, kb);
         if (ka) adat++;
         if (kb) bdat++;
         if (i == 1) begin
            chk("bp_count3", 32'(count), 32'd3);
            chk("bp_a_ready0", 32'(a_ready), 32'd0);
            chk("bp_b_ready1", 32'(b_ready), 32'd1);
         end
      end
      for (int i = 0; i < 5; i++) idle('0, 1'b0);
      chk("bp_drained", 32'(count), 32'd0);

      // Hazard query: younger entry wins
      step(1'b0, 1'b1, 6'd5, 1'b0, 32'd10, 1'b1, 6'd5, 1'b0, 32'd20, 6'd5, 1'b0, ka, kb);
      chk("haz_pend", 32'(q_pending), 32'd1);
      chk("haz_data", q_data, 32'd20);
      idle(6'd5, 1'b0);
      idle(6'd5, 1'b0);
      idle(6'd5, 1'b0);
      chk("haz_clear_pend", 32'(q_pending), 32'd0);
      chk("haz_clear_data", q_data, 32'd0);

      // Integer reg 0 dropped, float reg 0 written
      step(1'b0, 1'b1, 6'd0, 1'b0, 32'd99, 1'b0, '0, 1'b0, '0, '0, 1'b0, ka, kb);
      chk("r0_accepted", 32'(ka), 32'd1);
      chk("r0_count", 32'(count), 32'd0);
      idle('0, 1'b0);
      chk("r0_no_write", 32'(regWrite), 32'd0);
      step(1'b0, 1'b1, 6'd0, 1'b1, 32'd99, 1'b0, '0, 1'b0, '0, '0, 1'b1, ka, kb);
      idle('0, 1'b1);
      chk("f0_write", 32'(regWrite), 32'd1);
      chk("f0_float", 32'(wfloat), 32'd1);
      chk("f0_data", writeData, 32'd99);
      idle('0, 1'b0);

      // Mid-operation reset with three entries queued
      step(1'b0, 1'b1, 6'd7, 1'b0, 32'd1, 1'b1, 6'd8, 1'b0, 32'd2, '0, 1'b0, ka, kb);
      step(1'b0, 1'b1, 6'd9, 1'b0, 32'd3, 1'b1, 6'd12, 1'b0, 32'd4, '0, 1'b0, ka, kb);
      chk("mr_count3", 32'(count), 32'd3);
      step(1'b1, 1'b1, 6'd13, 1'b0, 32'd5, 1'b1, 6'd14, 1'b0, 32'd6, '0, 1'b0, ka, kb);
      chk("mr_count0", 32'(count), 32'd0);
      chk("mr_rw0", 32'(regWrite), 32'd0);
      chk("mr_data0", writeData, 32'd0);
      for (int i = 0; i < 4; i++) begin
         idle('0, 1'b0);
         chk("mr_no_write", 32'(regWrite), 32'd0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), $urandom,
              1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), $urandom,
              6'($urandom_range(0, 7)), 1'($urandom), ka, kb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
